// File: rtl/boot_sequencer_pkg.sv
// Shared definitions for the boot sequencer: FSM states, command/opcode defaults
// and the instruction field split.
package boot_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        RECV_LO,
        RECV_HI,
        RUN,
        HALTED
    } state_t;

    localparam logic [7:0]  START_CMD_DEF = 8'hA5;
    localparam logic [4:0]  HALT_OP_DEF   = 5'b00000;
    localparam int unsigned BITS_DEF      = 16;
    localparam int unsigned OP_FIELD_DEF  = 5;

    function automatic int unsigned dt_bits(input int unsigned bits);
        return bits - OP_FIELD_DEF;
    endfunction

    function automatic int unsigned op_bits(input int unsigned bits, input int unsigned dtbits);
        return bits - dtbits;
    endfunction

endpackage

// File: rtl/boot_sequencer_rx_watchdog.sv
// Inter-byte watchdog: reloads on every kick, counts down while active and
// flags expiry once a full TIMEOUT of idle cycles has elapsed.
module rx_watchdog #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    input  logic active,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] RELOAD = W'(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || !active || kick) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = active && !kick && (count == '0);

endmodule

// File: rtl/boot_sequencer.sv
// Loads a UART-delivered program into program memory, then releases the CPU
// and supervises it until a HALT opcode is fetched.
module boot_sequencer
    import boot_sequencer_pkg::*;
#(
    parameter int unsigned     BITS      = BITS_DEF,
    parameter int unsigned     DTBITS    = dt_bits(BITS),
    parameter int unsigned     OPBITS    = op_bits(BITS, DTBITS),
    parameter logic [OPBITS-1:0] HALT_OP = OPBITS'(HALT_OP_DEF),
    parameter logic [7:0]      START_CMD = START_CMD_DEF,
    parameter int unsigned     TIMEOUT   = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic [BITS-1:0]   i_instr,
    output logic              o_pm_we,
    output logic [DTBITS-1:0] o_pm_waddr,
    output logic [BITS-1:0]   o_pm_wdata,
    output logic              o_cpu_rst,
    output logic              o_cpu_en,
    output logic              o_done,
    output logic              o_error
);

    localparam int unsigned MAX_LEN = 2 ** DTBITS;

    state_t            state, state_d;
    logic [15:0]       len_q, len_d, len_new;
    logic [DTBITS:0]   cnt_q, cnt_d, cnt_inc;
    logic [7:0]        lo_q, lo_d;
    logic              pm_we_d, cpu_rst_d, cpu_en_d, done_d, error_d;
    logic [DTBITS-1:0] waddr_d;
    logic [BITS-1:0]   wdata_d;
    logic              load_state, wd_expired, halt_seen;
    logic              unused_instr_bits;

    assign load_state = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == RECV_LO) || (state == RECV_HI);
    assign halt_seen  = o_cpu_en && (i_instr[BITS-1:DTBITS] == HALT_OP);
    assign unused_instr_bits = ^i_instr[DTBITS-1:0];

    rx_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_rx_watchdog (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .kick    (i_rx_valid),
        .active  (load_state),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state;
        len_d     = len_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        pm_we_d   = 1'b0;
        waddr_d   = o_pm_waddr;
        wdata_d   = o_pm_wdata;
        cpu_rst_d = 1'b0;
        cpu_en_d  = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        len_new   = {i_rx_data, len_q[7:0]};
        cnt_inc   = cnt_q + 1'b1;

        unique case (state)
            IDLE: begin
                if (i_rx_valid && (i_rx_data == START_CMD)) begin
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (i_rx_valid) begin
                    len_d   = {8'h00, i_rx_data};
                    state_d = LEN_HI;
                end else if (wd_expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            LEN_HI: begin
                if (i_rx_valid) begin
                    len_d = len_new;
                    if ((len_new == 16'd0) || (32'(len_new) > MAX_LEN)) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = RECV_LO;
                    end
                end else if (wd_expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            RECV_LO: begin
                if (i_rx_valid) begin
                    lo_d    = i_rx_data;
                    state_d = RECV_HI;
                end else if (wd_expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            RECV_HI: begin
                if (i_rx_valid) begin
                    pm_we_d = 1'b1;
                    waddr_d = cnt_q[DTBITS-1:0];
                    wdata_d = BITS'({i_rx_data, lo_q});
                    cnt_d   = cnt_inc;
                    state_d = (32'(cnt_inc) == 32'(len_q)) ? RUN : RECV_LO;
                end else if (wd_expired) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            // RUN's first cycle is the final write cycle; the CPU is released one cycle later.
            RUN: begin
                cpu_rst_d = 1'b1;
                cpu_en_d  = 1'b1;
                if (halt_seen) begin
                    cpu_en_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = HALTED;
                end
            end
            HALTED: begin
                cpu_rst_d = 1'b1;
                done_d    = 1'b1;
                if (i_rx_valid && (i_rx_data == START_CMD)) begin
                    cpu_rst_d = 1'b0;
                    done_d    = 1'b0;
                    state_d   = LEN_LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            lo_q       <= '0;
            o_pm_we    <= 1'b0;
            o_pm_waddr <= '0;
            o_pm_wdata <= '0;
            o_cpu_rst  <= 1'b0;
            o_cpu_en   <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            state      <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            lo_q       <= lo_d;
            o_pm_we    <= pm_we_d;
            o_pm_waddr <= waddr_d;
            o_pm_wdata <= wdata_d;
            o_cpu_rst  <= cpu_rst_d;
            o_cpu_en   <= cpu_en_d;
            o_done     <= done_d;
            o_error    <= error_d;
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: byte-level sessions are turned into
// expected memory writes by a simple word model and compared with a monitor log.
module tb_boot_sequencer;

    localparam int unsigned BITS   = 16;
    localparam int unsigned DTBITS = 11;
    localparam int unsigned TMO    = 40;
    localparam logic [7:0]  A5     = 8'hA5;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic [BITS-1:0]   i_instr;
    logic              o_pm_we;
    logic [DTBITS-1:0] o_pm_waddr;
    logic [BITS-1:0]   o_pm_wdata;
    logic              o_cpu_rst;
    logic              o_cpu_en;
    logic              o_done;
    logic              o_error;

    boot_sequencer #(
        .BITS    (BITS),
        .DTBITS  (DTBITS),
        .TIMEOUT (TMO)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .i_instr    (i_instr),
        .o_pm_we    (o_pm_we),
        .o_pm_waddr (o_pm_waddr),
        .o_pm_wdata (o_pm_wdata),
        .o_cpu_rst  (o_cpu_rst),
        .o_cpu_en   (o_cpu_en),
        .o_done     (o_done),
        .o_error    (o_error)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor log, sampled on the falling edge
    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    int   cyc = 0;
    int   st_q[$];
    wr_t  wr_q[$];
    int   err_cnt = 0;
    int   err_cyc = 0;
    int   en_rise = -1;
    int   rst_rise = -1;
    logic prev_en = 1'b0;
    logic prev_rst = 1'b0;

    always @(negedge i_clk) begin
        wr_t w;
        cyc++;
        if (i_rx_valid) st_q.push_back(cyc);
        if (o_pm_we) begin
            w.addr = int'(o_pm_waddr);
            w.data = int'(o_pm_wdata);
            w.cyc  = cyc;
            wr_q.push_back(w);
        end
        if (o_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (o_cpu_en && !prev_en) en_rise = cyc;
        if (o_cpu_rst && !prev_rst) rst_rise = cyc;
        prev_en  = o_cpu_en;
        prev_rst = o_cpu_rst;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick(1);
        i_rx_valid = 1'b0;
        tick(gap);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_we"},    32'(o_pm_we),    32'd0);
        check({tag, "_waddr"}, 32'(o_pm_waddr), 32'd0);
        check({tag, "_wdata"}, 32'(o_pm_wdata), 32'd0);
        check({tag, "_cpurst"}, 32'(o_cpu_rst), 32'd0);
        check({tag, "_cpuen"}, 32'(o_cpu_en),   32'd0);
        check({tag, "_done"},  32'(o_done),     32'd0);
        check({tag, "_error"}, 32'(o_error),    32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        i_rst = 1'b0;
        tick(1);
        check_reset_outs(tag);
        i_rst = 1'b1;
        tick(1);
    endtask

    // Full load session; the model expects word i = {byte 2i+1, byte 2i} at address i,
    // written one cycle after its high byte, and the CPU released one cycle after that.
    task automatic load(input string tag, input logic [7:0] dat[$], input int gapmax);
        int          len;
        int          st_base, wr_base, err_base;
        int          last_wr;
        logic [7:0]  junk;
        logic [15:0] exp_w;
        len  = dat.size() / 2;
        junk = 8'($urandom_range(0, 255));
        if (junk == A5) junk = 8'h5A;
        send_byte(junk, int'($urandom_range(0, 2)));
        st_base  = st_q.size();
        wr_base  = wr_q.size();
        err_base = err_cnt;
        send_byte(A5, int'($urandom_range(0, gapmax)));
        send_byte(8'(len), int'($urandom_range(0, gapmax)));
        send_byte(8'(len >> 8), int'($urandom_range(0, gapmax)));
        for (int i = 0; i < dat.size(); i++) send_byte(dat[i], int'($urandom_range(0, gapmax)));
        tick(4);
        check({tag, "_wr_count"}, 32'(wr_q.size() - wr_base), 32'(len));
        last_wr = -100;
        for (int i = 0; i < len && (wr_base + i) < wr_q.size(); i++) begin
            exp_w = {dat[2*i+1], dat[2*i]};
            check({tag, "_addr"}, 32'(wr_q[wr_base+i].addr), 32'(i));
            check({tag, "_data"}, 32'(wr_q[wr_base+i].data), 32'(exp_w));
            check({tag, "_wr_lat"}, 32'(wr_q[wr_base+i].cyc), 32'(st_q[st_base+4+2*i] + 1));
            last_wr = wr_q[wr_base+i].cyc;
        end
        check({tag, "_no_err"}, 32'(err_cnt - err_base), 32'd0);
        check({tag, "_en_rise"}, 32'(en_rise), 32'(last_wr + 1));
        check({tag, "_rst_rise"}, 32'(rst_rise), 32'(last_wr + 1));
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 20 && !o_done; k++) tick(1);
        check({tag, "_done"}, 32'(o_done), 32'd1);
        check({tag, "_en_off"}, 32'(o_cpu_en), 32'd0);
    endtask

    task automatic bad_len(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        int wr_base, err_base;
        wr_base  = wr_q.size();
        err_base = err_cnt;
        send_byte(A5, 0);
        send_byte(lo, 0);
        send_byte(hi, 0);
        tick(4);
        check({tag, "_err"}, 32'(err_cnt - err_base), 32'd1);
        check({tag, "_no_wr"}, 32'(wr_q.size() - wr_base), 32'd0);
        check({tag, "_cpurst"}, 32'(o_cpu_rst), 32'd0);
        check({tag, "_err_pulse"}, 32'(o_error), 32'd0);
    endtask

    task automatic rand_data(input int len, input bit with_a5, output logic [7:0] dat[$]);
        dat.delete();
        for (int i = 0; i < 2 * len; i++) dat.push_back(8'($urandom_range(0, 255)));
        if (with_a5) dat[$urandom_range(0, 2 * len - 1)] = A5;
    endtask

    initial begin
        logic [7:0] dat[$];
        int         wr_base, err_base, st_last, en_cnt;

        i_rst      = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        i_instr    = 16'h0800;
        tick(3);
        check_reset_outs("reset");
        i_rst = 1'b1;
        tick(2);

        // Directed load, then halt after five enabled cycles
        dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        load("normal", dat, 2);
        en_cnt = 0;
        for (int k = 0; k < 50 && en_cnt < 5; k++) begin
            if (o_cpu_en) en_cnt++;
            if (en_cnt < 5) tick(1);
        end
        check("halt_en_cycles", 32'(en_cnt), 32'd5);
        i_instr = 16'h0000;
        tick(1);
        check("halt_en", 32'(o_cpu_en), 32'd0);
        check("halt_done", 32'(o_done), 32'd1);
        check("halt_cpurst", 32'(o_cpu_rst), 32'd1);
        wr_base = wr_q.size();
        send_byte(8'h11, 1);
        send_byte(8'h5A, 1);
        tick(2);
        check("halted_done", 32'(o_done), 32'd1);
        check("halted_en", 32'(o_cpu_en), 32'd0);
        check("halted_cpurst", 32'(o_cpu_rst), 32'd1);
        check("halted_no_wr", 32'(wr_q.size() - wr_base), 32'd0);

        // Back-to-back bytes with START_CMD as data
        dat = '{A5, 8'h3C, A5, A5};
        load("b2b", dat, 0);
        wait_done("b2b");

        bad_len("len0", 8'h00, 8'h00);
        bad_len("len2049", 8'h01, 8'h08);

        // Timeout mid-word
        wr_base  = wr_q.size();
        err_base = err_cnt;
        send_byte(A5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        st_last = st_q[$];
        tick(TMO + 10);
        check("tmo_err", 32'(err_cnt - err_base), 32'd1);
        check("tmo_no_wr", 32'(wr_q.size() - wr_base), 32'd0);
        check("tmo_lat_ok", 32'((err_cyc - st_last >= int'(TMO)) && (err_cyc - st_last <= int'(TMO) + 2)), 32'd1);
        check("tmo_cpurst", 32'(o_cpu_rst), 32'd0);

        dat = '{8'hDE, 8'hAD};
        load("after_tmo", dat, 1);
        wait_done("after_tmo");

        for (int s = 0; s < 6; s++) begin
            rand_data(int'($urandom_range(1, 8)), s[0], dat);
            load("rand", dat, 2);
            wait_done("rand");
        end

        // Full-size program: last address 2**DTBITS-1
        rand_data(2 ** DTBITS, 1'b1, dat);
        load("maxlen", dat, 0);
        wait_done("maxlen");

        // Reset while waiting for a high byte
        wr_base = wr_q.size();
        send_byte(A5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h77, 0);
        pulse_reset("rst_recv");
        check("rst_recv_no_wr", 32'(wr_q.size() - wr_base), 32'd0);

        // Reset while the CPU runs
        i_instr = 16'h0800;
        rand_data(3, 1'b0, dat);
        load("pre_run_rst", dat, 1);
        tick(3);
        check("run_en", 32'(o_cpu_en), 32'd1);
        pulse_reset("rst_run");
        i_instr = 16'h0000;

        rand_data(2, 1'b1, dat);
        load("recover", dat, 1);
        wait_done("recover");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Loads a program received as UART bytes into program memory, then releases the CPU and supervises execution until a HALT opcode is fetched.
- Sits between the UART receiver, program memory write port and CPU control path (PC/decoder reset and enable).
- Holds the CPU in reset while loading, so the PC restarts at address 0 on every run.

Parameters:
- BITS, 16, instruction width.
- DTBITS, BITS-5, address/operand field width (PC width).
- OPBITS, BITS-DTBITS, opcode field width.
- HALT_OP, 5'b00000, opcode that ends a run.
- START_CMD, 8'hA5, byte that starts a load session.
- TIMEOUT, 1000000, max idle clocks between bytes inside a session.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous reset, active-low (reset when 0 at posedge i_clk).
- i_rx_data  input  8  received UART byte.
- i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid.
- i_instr  input  BITS  instruction currently fetched by the CPU.
- o_pm_we  output  1  program memory write strobe.
- o_pm_waddr  output  DTBITS  program memory write address.
- o_pm_wdata  output  BITS  program memory write data.
- o_cpu_rst  output  1  CPU reset, active-low, drives CPU i_rst.
- o_cpu_en  output  1  CPU clock-enable (PC advance / decoder enable).
- o_done  output  1  high while HALTED.
- o_error  output  1  one-cycle pulse on protocol error or timeout.

Behaviour:
- All outputs are registered. Reset values: state IDLE, o_pm_we 0, o_pm_waddr 0, o_pm_wdata 0, o_cpu_rst 0, o_cpu_en 0, o_done 0, o_error 0, word counter 0, length 0.
- States: IDLE, LEN_LO, LEN_HI, RECV_LO, RECV_HI, RUN, HALTED.
- IDLE: on a byte equal to START_CMD, go to LEN_LO. Other bytes are ignored.
- LEN_LO / LEN_HI: capture the 16-bit word count, low byte first.
  - After LEN_HI, a count of 0 or greater than 2**DTBITS raises o_error and returns to IDLE.
  - Otherwise clear the counter and go to RECV_LO.
- RECV_LO: latch the low byte, then go to RECV_HI.
- RECV_HI: on a byte, in the next cycle o_pm_we=1, o_pm_wdata={byte, lo}, o_pm_waddr=counter.
  - The counter increments in that same cycle.
  - If the incremented counter equals the length, go to RUN; else go to RECV_LO.
  - Write latency is 1 cycle from the hi strobe. A new byte may arrive in the very next cycle.
- In all load states, START_CMD bytes are treated as data, not commands.
- In LEN_LO, LEN_HI, RECV_LO and RECV_HI:
  - The watchdog reloads on every i_rx_valid.
  - When the watchdog reaches TIMEOUT cycles without a byte: one-cycle o_error, state IDLE, no further writes.
- o_cpu_rst=0 in IDLE and in all load states.
- RUN:
  - Entered the cycle after the last write. o_cpu_rst=1 and o_cpu_en=1.
  - rx bytes are ignored.
  - When o_cpu_en=1 and i_instr[BITS-1:DTBITS]==HALT_OP: next cycle go to HALTED, o_cpu_en=0.
- HALTED: o_cpu_rst=1 (CPU state preserved for inspection), o_cpu_en=0, o_done=1. A START_CMD byte goes to LEN_LO, o_done=0, o_cpu_rst=0.
- o_pm_we is never asserted outside the cycle that follows a RECV_HI byte.
- Reset mid-load: return to IDLE. Partially written memory is left as is; the CPU stays in reset.
- Reset during RUN: CPU is forced back into reset and disabled.
- Width rules:
  - Counter is DTBITS+1 bits, so a length of 2**DTBITS is representable.
  - Address is the counter's low DTBITS bits; last address is 2**DTBITS-1, with no wrap.

Decomposition:
- Shared package holds:
  - the state encoding;
  - START_CMD and HALT_OP defaults;
  - the opcode field slice constants (BITS/DTBITS/OPBITS relation).
- One sub-module, rx_watchdog: loadable down-counter of clog2(TIMEOUT+1) bits with inputs kick and active, output expired.

Test Plan:
- Normal load: bytes A5,03,00,11,22,33,44,55,66 → writes addr0=2211, addr1=4433, addr2=6655, each one cycle after its hi byte. o_cpu_rst and o_cpu_en rise the cycle after the last write.
- Halt: run with i_instr driven to 16'h0000 after 5 enabled cycles → o_cpu_en=0 and o_done=1 the next cycle; further rx bytes other than A5 cause no change.
- Bad length: A5,00,00 → o_error pulse, state IDLE, no o_pm_we. Repeat with A5,01,08 (length 2049, DTBITS=11) → same result.
- Timeout: A5,02,00,11 then silence for TIMEOUT cycles → o_error exactly once, no write. A subsequent A5 session loads correctly.
- Back-to-back bytes: every byte strobed on consecutive cycles, length 2 → two writes, no byte lost. A5 used as a data byte is written as data.
- Reset: assert i_rst=0 mid-RECV_HI and again mid-RUN → all outputs at reset values the next cycle, o_cpu_rst=0.
